// File: rtl/adder_pkg.sv
// Purpose: shared FSM encoding and sizing helpers for the chunked adder.
// Ports:   none (package).
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of slice additions needed to cover one operand.
    function automatic int unsigned calc_nchunk(input int unsigned width,
                                                input int unsigned chunk);
        if (chunk == 0) return 1;
        return width / chunk;
    endfunction

    // Chunk index width; kept at least one bit so the counter always exists.
    function automatic int unsigned calc_idxw(input int unsigned nchunk);
        if (nchunk <= 1) return 1;
        return $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Purpose: operand/result handshake bundle for the chunked adder.
// Signals: in_valid/in_ready/a/b/cin (operand side),
//          out_valid/out_ready/sum/cout/ovf (result side).
// Modports: master = producer/consumer of the adder, slave = the adder.
interface chunked_adder_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/adder_chunk.sv
// Purpose: combinational CHUNK-bit ripple-carry adder slice.
// Ports:   i_a, i_b  (CHUNK) addends
//          i_cin     carry into bit 0
//          o_s       (CHUNK) slice sum
//          o_cout    carry out of the top bit
module adder_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout
);

    logic w_c;

    // Ripple of CHUNK full adders; w_c carries between bit positions.
    always_comb begin
        o_s = '0;
        w_c = i_cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end

endmodule

// File: rtl/chunked_adder.sv
// Purpose: multi-cycle WIDTH-bit adder that adds CHUNK bits per clock through
//          a single slice, with valid/ready handshakes on both sides.
// Ports:   clk    rising-edge clock
//          rst_n  synchronous active-low reset
//          io_bus slave side of chunked_adder_if (operands in, sum/cout/ovf out)
module chunked_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    chunked_adder_if.slave  io_bus
);

    localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int unsigned IDXW   = calc_idxw(NCHUNK);

    generate
        if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_adder: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)",
                   WIDTH, CHUNK);
        end
    endgenerate

    state_t            r_state;
    state_t            w_next_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic [IDXW-1:0]   r_idx;

    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic [31:0]       w_base;
    logic [CHUNK-1:0]  w_a_slice;
    logic [CHUNK-1:0]  w_b_slice;
    logic [CHUNK-1:0]  w_s;
    logic              w_c;

    // Operand slice currently being added.
    assign w_base    = 32'(r_idx) * 32'(CHUNK);
    assign w_a_slice = r_a[w_base +: CHUNK];
    assign w_b_slice = r_b[w_base +: CHUNK];
    assign w_last    = (r_idx == IDXW'(NCHUNK - 1));

    adder_chunk #(.CHUNK(CHUNK)) u_slice (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    // State register plus the registered handshake outputs derived from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state == ST_IDLE);
            r_out_valid <= (w_next_state == ST_DONE);
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.in_valid && r_in_ready) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (io_bus.out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Operand capture and one slice of the sum per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (w_load) begin
            r_a     <= io_bus.a;
            r_b     <= io_bus.b;
            r_carry <= io_bus.cin;
            r_idx   <= '0;
        end else if (w_step) begin
            r_sum[w_base +: CHUNK] <= w_s;
            r_carry                <= w_c;
            r_idx                  <= w_last ? '0 : r_idx + IDXW'(1);
            if (w_last) begin
                r_cout <= w_c;
                // Top slice sum bit is the result MSB.
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[CHUNK-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.sum       = r_sum;
    assign io_bus.cout      = r_cout;
    assign io_bus.ovf       = r_ovf;

endmodule

// File: tb/tb_chunked_adder.sv
// Purpose: self-checking bench for chunked_adder (16/4 and 4/4 configurations).
module tb_chunked_adder;

    logic clk = 1'b0;
    logic rst16_n;
    logic rst4_n;

    always #5 clk = ~clk;

    chunked_adder_if #(.WIDTH(16)) bus16 ();
    chunked_adder_if #(.WIDTH(4))  bus4 ();

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk    (clk),
        .rst_n  (rst16_n),
        .io_bus (bus16)
    );

    chunked_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst4_n),
        .io_bus (bus4)
    );

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    exp_t q16[$];
    exp_t q4[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] t;
        exp_t        e;
        t      = {1'b0, a} + {1'b0, b} + 17'(c);
        e.sum  = t[15:0];
        e.cout = t[16];
        e.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
        return e;
    endfunction

    function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] t;
        exp_t       e;
        t      = {1'b0, a} + {1'b0, b} + 5'(c);
        e.sum  = 16'(t[3:0]);
        e.cout = t[4];
        e.ovf  = (a[3] == b[3]) && (t[3] != a[3]);
        return e;
    endfunction

    // Present operands, wait for acceptance, record expected result.
    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic c, input exp_t e);
        int n;
        n = 0;
        bus16.a        = a;
        bus16.b        = b;
        bus16.cin      = c;
        bus16.in_valid = 1'b1;
        while (bus16.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("accept16_ready", 32'(bus16.in_ready), 32'd1);
        tick();
        bus16.in_valid = 1'b0;
        q16.push_back(e);
    endtask

    // Wait for the result, compare, optionally stall, then drain.
    task automatic finish16(input int hold);
        int   lat;
        exp_t e;
        lat = 1;
        while (bus16.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency16", 32'(lat), 32'd5);
        if (q16.size() == 0) begin
            chk("sb16_nonempty", 32'(q16.size()), 32'd1);
            return;
        end
        e = q16.pop_front();
        chk("sum16",  32'(bus16.sum),  32'(e.sum));
        chk("cout16", 32'(bus16.cout), 32'(e.cout));
        chk("ovf16",  32'(bus16.ovf),  32'(e.ovf));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid16", 32'(bus16.out_valid), 32'd1);
            chk("hold_ready16", 32'(bus16.in_ready),  32'd0);
            chk("hold_sum16",   32'(bus16.sum),       32'(e.sum));
            chk("hold_cout16",  32'(bus16.cout),      32'(e.cout));
            chk("hold_ovf16",   32'(bus16.ovf),       32'(e.ovf));
        end
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
        chk("drain_valid16", 32'(bus16.out_valid), 32'd0);
        chk("drain_ready16", 32'(bus16.in_ready),  32'd1);
    endtask

    // Full operation on the single-chunk instance.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, input exp_t e);
        int   n;
        int   lat;
        exp_t got;
        n = 0;
        bus4.a        = a;
        bus4.b        = b;
        bus4.cin      = c;
        bus4.in_valid = 1'b1;
        while (bus4.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus4.in_valid = 1'b0;
        q4.push_back(e);
        lat = 1;
        while (bus4.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency4", 32'(lat), 32'd2);
        got = q4.pop_front();
        chk("sum4",  32'(bus4.sum),  32'(got.sum[3:0]));
        chk("cout4", 32'(bus4.cout), 32'(got.cout));
        chk("ovf4",  32'(bus4.ovf),  32'(got.ovf));
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        exp_t e;
        int   seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst16_n         = 1'b0;
        rst4_n          = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.cin       = 1'b0;
        bus4.in_valid   = 1'b0;
        bus4.out_ready  = 1'b0;
        bus4.a          = '0;
        bus4.b          = '0;
        bus4.cin        = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_in_ready",  32'(bus16.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst_sum",       32'(bus16.sum),       32'd0);
        chk("rst_cout",      32'(bus16.cout),      32'd0);
        chk("rst_ovf",       32'(bus16.ovf),       32'd0);
        chk("rst4_in_ready", 32'(bus4.in_ready),   32'd0);
        rst16_n = 1'b1;
        rst4_n  = 1'b1;
        tick();
        chk("release_in_ready",  32'(bus16.in_ready), 32'd1);
        chk("release4_in_ready", 32'(bus4.in_ready),  32'd1);

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            e.sum  = vecs[i].sum;
            e.cout = vecs[i].cout;
            e.ovf  = vecs[i].ovf;
            start16(vecs[i].a, vecs[i].b, vecs[i].cin, e);
            finish16(0);
        end

        // Random operands against the behavioural model.
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            start16(ra, rb, rc, model16(ra, rb, rc));
            finish16(i % 2);
        end

        // Backpressure: new operands held valid during RUN/DONE must not be taken.
        e.sum = 16'h3333; e.cout = 1'b0; e.ovf = 1'b0;
        start16(16'h1111, 16'h2222, 1'b0, e);
        bus16.a        = 16'hAAAA;
        bus16.b        = 16'h5555;
        bus16.cin      = 1'b1;
        bus16.in_valid = 1'b1;
        finish16(3);
        e.sum = 16'h0000; e.cout = 1'b1; e.ovf = 1'b0;
        start16(16'hAAAA, 16'h5555, 1'b1, e);
        finish16(0);

        // Reset during the second RUN cycle aborts the operation.
        start16(16'h7FFF, 16'h7FFF, 1'b1, model16(16'h7FFF, 16'h7FFF, 1'b1));
        tick();
        rst16_n = 1'b0;
        tick();
        chk("abort_in_ready",  32'(bus16.in_ready),  32'd0);
        chk("abort_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("abort_sum",       32'(bus16.sum),       32'd0);
        chk("abort_cout",      32'(bus16.cout),      32'd0);
        chk("abort_ovf",       32'(bus16.ovf),       32'd0);
        rst16_n = 1'b1;
        q16.delete();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus16.out_valid === 1'b1) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        chk("abort_idle_ready", 32'(bus16.in_ready), 32'd1);
        start16(16'h00FF, 16'h0001, 1'b0, model16(16'h00FF, 16'h0001, 1'b0));
        finish16(0);

        // Single-chunk configuration: directed case then exhaustive sweep.
        e.sum = 16'h0007; e.cout = 1'b1; e.ovf = 1'b1;
        op4(4'b1100, 4'b1010, 1'b1, e);
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    op4(4'(ia), 4'(ib), 1'(ic), model4(4'(ia), 4'(ib), 1'(ic)));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
